impulse_capture: RTL
====================

# impulse_capture

Receive-side counterpart to the impulse generator. Arms on the rising edge of the generator's `impulse_out`, measures the delay in audio steps until the microphone sample crosses a magnitude threshold, then records a fixed-length impulse-response window into an internal buffer. The buffer is read back through a synchronous read port. Used for acoustic latency and room-response measurement.

## Interface
- `CAPTURE_LEN`, 256: samples stored per capture; power of two, 2..1024.
- `MAX_WAIT`, 1023: maximum `step_in` strobes to wait for detection before timeout; must fit in 16 bits.
- `THRESHOLD`, 16'sd4096: detection magnitude; positive signed 16-bit.
- `clk_in` input, 1 bit: system clock.
- `rst_in` input, 1 bit: reset; synchronous, active-low.
- `step_in` input, 1 bit: one-cycle audio sample strobe.
- `impulse_in` input, 1 bit: trigger, driven by the generator's `impulse_out`; level signal, rising edge used.
- `amp_in` input, signed 16 bits: microphone sample; valid when `step_in`=1.
- `rd_addr_in` input, $clog2(CAPTURE_LEN) bits: buffer read address.
- `rd_data_out` output, signed 16 bits: buffer word at the previous cycle's `rd_addr_in`.
- `busy_out` output, 1 bit: high in ARMED and CAPTURING.
- `done_out` output, 1 bit: one-cycle pulse at the end of a capture or timeout.
- `timeout_out` output, 1 bit: latched high when the last run timed out.
- `delay_out` output, 16 bits: steps from arm to detection for the last run.
- `peak_out` output, signed 16 bits: maximum magnitude in the last capture window.

## Operation
- Edge detect: register `impulse_in`. `start` = `impulse_in` & ~registered value. The registered value resets to 0.
- States:
  - IDLE -> ARMED on `start`. On entry: clear the step counter and `timeout_out`, and set `busy_out`.
  - ARMED, on each `step_in`:
    - mag = |amp_in|, with -32768 saturated to 32767.
    - If mag >= THRESHOLD: `delay_out` <= counter, write `amp_in` to buffer[0], peak <= mag, write index <= 1, go to CAPTURING.
    - Else if counter == MAX_WAIT: `timeout_out` <= 1, `delay_out` <= MAX_WAIT, go to DONE.
    - Else: counter + 1.
  - CAPTURING, on each `step_in`:
    - Write `amp_in` to buffer[index] and update the peak with mag.
    - When index == CAPTURE_LEN-1 on the writing step, go to DONE. Otherwise index + 1.
  - DONE: `done_out` = 1 for this single cycle, `busy_out` <= 0, go to IDLE.
- `start` while in ARMED, CAPTURING or DONE is ignored. No re-arm occurs.
- `step_in` cycles outside ARMED/CAPTURING write nothing.
- A timeout leaves buffer contents from the previous run untouched; `peak_out` is cleared to 0.
- Buffer: single-port write, independent synchronous read. Inferred as block RAM. Contents are not reset.
- Reading an address during the cycle it is written returns the old data.

## Timing
- Reset values: `busy_out`=0, `done_out`=0, `timeout_out`=0, `delay_out`=0, `peak_out`=0, `rd_data_out`=0, state IDLE.
- `start` is seen the cycle after `impulse_in` rises; `busy_out` rises one cycle later.
- A `step_in` coincident with the ARMED-entry cycle is not evaluated. Evaluation begins with the next strobe.
- Detection on the first evaluated strobe gives `delay_out`=0.
- `delay_out`, `peak_out` and `timeout_out` are valid from the `done_out` cycle and hold until the next arm.
- `rd_data_out` latency: 1 cycle.
- Reset asserted mid-run aborts immediately to IDLE with no `done_out`.

## Configuration
- `IMPULSE_CAPTURE_PEAK_EN` defined: peak magnitude tracking as described.
- `IMPULSE_CAPTURE_PEAK_EN` undefined: no comparator or peak register; `peak_out` is tied to 16'sd0.
- All other behaviour is identical in both builds.

## Test plan
- **Basic capture.** `impulse_in` rises. `amp_in`=0 for 5 strobes, then 16'sd5000, then a ramp of 1..255.
  - Required: `delay_out`=5, `done_out` pulses once after the 256th stored sample, `timeout_out`=0.
  - Required readback: buffer[0]=5000, buffer[k]=k.
- **Timeout.** MAX_WAIT=10, `amp_in`=100 constant.
  - Required: `done_out` on the cycle after the 11th evaluated strobe, `timeout_out`=1, `delay_out`=10, previous buffer contents unchanged.
- **Saturating magnitude and peak.** Detect on -32768.
  - Required: capture starts, `peak_out`=32767 (with `IMPULSE_CAPTURE_PEAK_EN`), 0 without it.
- **Re-trigger ignored.** Toggle `impulse_in` low then high during CAPTURING.
  - Required: a single `done_out`; the run length is unchanged.
- **Threshold boundary.** Strobe `amp_in`=4095, then -4096.
  - Required: 4095 is not detected; -4096 is detected with `delay_out`=1.
- **Reset mid-run.** Pull `rst_in` low during CAPTURING.
  - Required: next cycle `busy_out`=0 and all outputs at reset values; no `done_out`.

Source files
------------

// File: rtl/impulse_capture.sv
// Impulse-response capture: arms on a rising impulse_in, times the delay to a threshold crossing,
// then stores CAPTURE_LEN samples for readback. Define IMPULSE_CAPTURE_PEAK_EN to enable peak tracking.
module impulse_capture #(
   parameter int                 CAPTURE_LEN = 256,
   parameter int                 MAX_WAIT    = 1023,
   parameter logic signed [15:0] THRESHOLD   = 16'sd4096
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           step_in,
   input  logic                           impulse_in,
   input  logic signed [15:0]             amp_in,
   input  logic [$clog2(CAPTURE_LEN)-1:0] rd_addr_in,
   output logic signed [15:0]             rd_data_out,
   output logic                           busy_out,
   output logic                           done_out,
   output logic                           timeout_out,
   output logic [15:0]                    delay_out,
   output logic signed [15:0]             peak_out
);

   localparam int          AW       = $clog2(CAPTURE_LEN);
   localparam logic [15:0] MAX_W    = 16'(MAX_WAIT);
   localparam logic [15:0] THR_U    = 16'(THRESHOLD);
   localparam logic [AW-1:0] LAST_IDX = AW'(CAPTURE_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_CAPT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Magnitude with the most negative code saturated so it stays representable.
   function automatic logic [15:0] sat_mag(input logic signed [15:0] a);
      if (a == 16'sh8000) begin
         return 16'd32767;
      end else if (a < 16'sd0) begin
         return 16'(-a);
      end else begin
         return 16'(a);
      end
   endfunction

   state_t                state_r;
   state_t                state_nx_s;
   logic                  imp_q_r;
   logic                  start_s;
   logic [15:0]           mag_s;
   logic [15:0]           cnt_r;
   logic [AW-1:0]         idx_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  timeout_r;
   logic [15:0]           delay_r;
   logic signed [15:0]    rd_data_r;
   logic signed [15:0]    mem_r [CAPTURE_LEN];

   logic                  arm_s;
   logic                  detect_s;
   logic                  tmo_s;
   logic                  wr_en_s;
   logic [AW-1:0]         wr_addr_s;
   logic                  cnt_inc_s;
   logic                  idx_inc_s;
   logic                  last_s;

   assign start_s = impulse_in & ~imp_q_r;
   assign mag_s   = sat_mag(amp_in);

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_nx_s = state_r;
      arm_s      = 1'b0;
      detect_s   = 1'b0;
      tmo_s      = 1'b0;
      wr_en_s    = 1'b0;
      wr_addr_s  = idx_r;
      cnt_inc_s  = 1'b0;
      idx_inc_s  = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start_s) begin
               state_nx_s = S_ARMED;
               arm_s      = 1'b1;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_ARMED: begin
            if (step_in) begin
               if (mag_s >= THR_U) begin
                  detect_s   = 1'b1;
                  wr_en_s    = 1'b1;
                  wr_addr_s  = '0;
                  state_nx_s = S_CAPT;
               end else if (cnt_r == MAX_W) begin
                  tmo_s      = 1'b1;
                  state_nx_s = S_DONE;
               end else begin
                  cnt_inc_s  = 1'b1;
               end
            end else begin
               state_nx_s = S_ARMED;
            end
         end
         S_CAPT: begin
            if (step_in) begin
               wr_en_s   = 1'b1;
               wr_addr_s = idx_r;
               if (idx_r == LAST_IDX) begin
                  last_s     = 1'b1;
                  state_nx_s = S_DONE;
               end else begin
                  idx_inc_s  = 1'b1;
               end
            end else begin
               state_nx_s = S_CAPT;
            end
         end
         S_DONE: begin
            state_nx_s = S_IDLE;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Edge detector, counters and result registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         imp_q_r   <= 1'b0;
         cnt_r     <= 16'd0;
         idx_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         timeout_r <= 1'b0;
         delay_r   <= 16'd0;
      end else begin
         imp_q_r <= impulse_in;
         busy_r  <= (state_nx_s == S_ARMED) || (state_nx_s == S_CAPT);
         done_r  <= (state_nx_s == S_DONE);
         if (arm_s) begin
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + 16'd1;
         end else if (tmo_s) begin
            timeout_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (detect_s) begin
            delay_r <= cnt_r;
         end else if (tmo_s) begin
            delay_r <= MAX_W;
         end else begin
            delay_r <= delay_r;
         end
         if (detect_s) begin
            idx_r <= AW'(1);
         end else if (idx_inc_s) begin
            idx_r <= idx_r + AW'(1);
         end else begin
            idx_r <= idx_r;
         end
      end
   end

`ifdef IMPULSE_CAPTURE_PEAK_EN
   logic [15:0] peak_run_r;
   logic [15:0] peak_r;

   function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a : b;
   endfunction

   // Running window peak; published only when the window closes, cleared on timeout.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         peak_run_r <= 16'd0;
         peak_r     <= 16'd0;
      end else begin
         if (detect_s) begin
            peak_run_r <= mag_s;
         end else if (wr_en_s) begin
            peak_run_r <= max_u16(peak_run_r, mag_s);
         end else begin
            peak_run_r <= peak_run_r;
         end
         if (last_s) begin
            peak_r <= max_u16(peak_run_r, mag_s);
         end else if (tmo_s) begin
            peak_r <= 16'd0;
         end else begin
            peak_r <= peak_r;
         end
      end
   end

   assign peak_out = $signed(peak_r);
`else
   assign peak_out = 16'sd0;
`endif

   // Capture buffer write port; contents deliberately not reset.
   always_ff @(posedge clk_in) begin
      if (rst_in && wr_en_s) begin
         mem_r[wr_addr_s] <= amp_in;
      end
   end

   // Synchronous read port (read-before-write on a colliding address).
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rd_data_r <= 16'sd0;
      end else begin
         rd_data_r <= mem_r[rd_addr_in];
      end
   end

   assign rd_data_out = rd_data_r;
   assign busy_out    = busy_r;
   assign done_out    = done_r;
   assign timeout_out = timeout_r;
   assign delay_out   = delay_r;

endmodule
